// File: rtl/seq_det_ctrl_if.sv
// Configuration, control and serial-stream bundle for the programmable sequence detector.
// The master side supplies config and bits; the slave side is the controller.
interface seq_det_ctrl_if #(
    parameter int PW = 8,
    parameter int CW = 8
);
    localparam int LW = $clog2(PW + 1);

    logic          cfg_valid;
    logic          cfg_ready;
    logic [PW-1:0] cfg_pat;
    logic [LW-1:0] cfg_len;
    logic          cfg_ovl;
    logic [CW-1:0] cfg_target;
    logic          cfg_err;
    logic          start;
    logic          abort;
    logic          In;
    logic          in_valid;
    logic          OP;
    logic [CW-1:0] match_cnt;
    logic          busy;
    logic          done;
    logic [1:0]    CS;

    modport master (
        output cfg_valid, cfg_pat, cfg_len, cfg_ovl, cfg_target, start, abort, In, in_valid,
        input  cfg_ready, cfg_err, OP, match_cnt, busy, done, CS
    );

    modport slave (
        input  cfg_valid, cfg_pat, cfg_len, cfg_ovl, cfg_target, start, abort, In, in_valid,
        output cfg_ready, cfg_err, OP, match_cnt, busy, done, CS
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable Mealy sequence detector: loads a pattern over a valid/ready handshake,
// counts matches on a gated serial stream and stops when the match target is reached.
//
// state | meaning
// IDLE  | waiting for config / start; cfg_ready high
// ARMED | shifting valid bits and detecting matches
// DONE  | match target reached; waits for start or new config
module seq_det_ctrl #(
    parameter int PW = 8,
    parameter int CW = 8
) (
    input logic          Clk,
    input logic          Rst,
    seq_det_ctrl_if.slave bus
);
    localparam int LW = $clog2(PW + 1);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ARMED = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    logic [1:0]    state_q, state_d;
    logic          loaded;
    logic [PW-1:0] pat_q;
    logic [LW-1:0] len_q;
    logic          ovl_q;
    logic [CW-1:0] target_q;
    logic [PW-1:0] hist;
    logic [LW-1:0] fill;
    logic [CW-1:0] cnt;
    logic          err_q;

    logic          xfer, cfg_bad, arm, hit, fill_ok;
    logic          busy_s, done_s, ready_s, op_s;
    logic [PW-1:0] shifted, mask;
    logic [CW-1:0] cnt_inc;

    assign xfer    = bus.cfg_valid & ready_s;
    assign cfg_bad = (bus.cfg_len == '0) || (bus.cfg_len > LW'(PW));
    assign arm     = bus.start & loaded & ~xfer;

    // Newest bit lands in position 0, so the low len bits line up with pat[len-1:0].
    assign shifted = {hist[PW-2:0], bus.In};
    assign mask    = ~({PW{1'b1}} << len_q);
    assign hit     = ((shifted ^ pat_q) & mask) == '0;
    assign fill_ok = fill >= (len_q - LW'(1));
    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm) state_d = ARMED;
            ARMED: begin
                if (bus.abort)
                    state_d = IDLE;
                else if (op_s && (target_q != '0) && (cnt_inc == target_q))
                    state_d = DONE;
            end
            DONE: begin
                if (xfer)     state_d = IDLE;
                else if (arm) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_s  = (state_q == ARMED);
        done_s  = (state_q == DONE);
        ready_s = (state_q == IDLE) || (state_q == DONE);
        op_s    = busy_s & bus.in_valid & ~bus.abort & fill_ok & hit;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            loaded   <= 1'b0;
            pat_q    <= '0;
            len_q    <= '0;
            ovl_q    <= 1'b0;
            target_q <= '0;
            hist     <= '0;
            fill     <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= xfer & cfg_bad;
            if (xfer && !cfg_bad) begin
                pat_q    <= bus.cfg_pat;
                len_q    <= bus.cfg_len;
                ovl_q    <= bus.cfg_ovl;
                target_q <= bus.cfg_target;
                loaded   <= 1'b1;
            end
            if (ready_s && arm) begin
                hist <= '0;
                fill <= '0;
                cnt  <= '0;
            end else if (busy_s && bus.in_valid && !bus.abort) begin
                hist <= shifted;
                // Non-overlapping mode restarts the window so the next match needs len fresh bits.
                if (op_s && !ovl_q)
                    fill <= '0;
                else if (fill != LW'(PW))
                    fill <= fill + LW'(1);
                if (op_s && (cnt != '1))
                    cnt <= cnt_inc;
            end
        end
    end

    assign bus.cfg_ready = ready_s;
    assign bus.cfg_err   = err_q;
    assign bus.OP        = op_s;
    assign bus.match_cnt = cnt;
    assign bus.busy      = busy_s;
    assign bus.done      = done_s;
    assign bus.CS        = state_q;
endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable controller for the team's Mealy overlapping/non-overlapping sequence detectors. It accepts a pattern configuration through a valid/ready handshake and arms detection on a serial input stream. It counts matches and stops with a done flag when a programmed match target is reached. It sits between the register/config side and the serial bit stream, and replaces the fixed-pattern 1010 detector instances.

Parameters:
PW, 8, maximum pattern length in bits (2..16)
CW, 8, width of the match counter and the target field

Ports:
Clk  input  1  clock; all state updates on the rising edge
Rst  input  1  asynchronous, active-low reset
cfg_valid  input  1  configuration request
cfg_ready  output  1  controller accepts configuration (high in IDLE and DONE)
cfg_pat  input  PW  pattern; bit [cfg_len-1] is the first bit received, bit 0 is the last
cfg_len  input  $clog2(PW+1)  pattern length; legal range 1..PW
cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  input  CW  match count that ends the run; 0 = run until abort
cfg_err  output  1  one-cycle pulse when a configuration is rejected
start  input  1  arm detection using the loaded configuration
abort  input  1  stop detection and return to IDLE
In  input  1  serial data bit
in_valid  input  1  In is sampled only when this is high
OP  output  1  Mealy match output (combinational)
match_cnt  output  CW  matches counted in the current run
busy  output  1  high in ARMED
done  output  1  high in DONE
CS  output  2  current state encoding

Behaviour:
- States and encoding: IDLE=2'b00, ARMED=2'b01, DONE=2'b10. 2'b11 is unreachable and recovers to IDLE.
- Reset (Rst low, asynchronous):
  - state IDLE, loaded=0, hist=0, fill=0, match_cnt=0, OP=0, done=0, busy=0, cfg_err=0, cfg_ready=1.
  - The stored configuration is cleared.
- Config handshake: a transfer occurs when cfg_valid & cfg_ready.
  - cfg_len of 0 or greater than PW: configuration not stored, cfg_err pulses the next cycle, loaded unchanged.
  - Otherwise pat/len/ovl/target are latched and loaded=1.
  - No transfer can occur in ARMED because cfg_ready=0 there.
- IDLE/DONE -> ARMED: on start & loaded & no config transfer that cycle; the config transfer has priority and start is ignored.
  - On arming: hist, fill and match_cnt are cleared.
  - start while loaded=0 is ignored.
- ARMED, on each cycle with in_valid=1:
  - hist <= {hist[PW-2:0], In}.
  - fill increments and saturates at PW.
- Match detection:
  - OP = busy & in_valid & ~abort & (fill >= len-1) & ({hist[len-2:0],In} == pat[len-1:0]). For len=1 the comparison is In == pat[0].
  - OP is combinational (Mealy) and asserts in the same cycle as the completing bit.
- On OP:
  - match_cnt increments and saturates at all-ones.
  - ovl=0: fill is cleared, so the next match needs len fresh bits.
  - ovl=1: fill is kept.
- ARMED -> DONE: on OP when target != 0 and match_cnt+1 == target. done stays high until the next start, a config transfer, or reset.
- ARMED -> IDLE on abort:
  - abort takes priority over a same-cycle match: OP=0 and match_cnt holds.
  - match_cnt stays readable after abort.
- in_valid=0: hist, fill and OP are held at their non-matching values; gaps are invisible to detection.
- match_cnt clears only on reset or on arming.

Test Plan:
- Pattern 1010, len=4, ovl=1, target=0; start; stream 1,0,1,0,1,0 -> OP high on bits 4 and 6, match_cnt=2, CS=01 throughout.
- Same stream with ovl=0 -> OP high on bit 4 only, match_cnt=1. Append 1,0 -> OP high on bit 8, match_cnt=2.
- Pattern 110, len=3, target=2; stream 1,1,0,1,1,0 -> second OP on bit 6, next cycle CS=10, done=1, busy=0. Later In bits produce no OP.
- cfg_len=0 and cfg_len=PW+1 -> cfg_err pulses once each, loaded stays 0, a following start leaves CS=00.
- Pattern 1010 with in_valid dropped for 3 cycles between bits 2 and 3 -> OP still on bit 4. Abort asserted in the same cycle as the 4th bit -> OP=0, match_cnt=0, CS=00.
- Rst driven low mid-run with match_cnt=3 -> immediately (asynchronously) CS=00, match_cnt=0, OP=0, cfg_ready=1; a start after release is ignored until a new configuration is loaded.
